// File: rtl/corr_pkg.sv
// Shared constants for the CORDIC range-restore path: Q16.32 format limits,
// mode encodings and restore FSM state encodings.
package corr_pkg;

    localparam int INTERNAL_WIDTH  = 48;
    localparam int FRACTIONAL_BITS = 32;
    localparam int COUNT_WIDTH     = 4;

    localparam logic signed [INTERNAL_WIDTH-1:0] ONE_POS = 48'sh0001_0000_0000;
    localparam logic signed [INTERNAL_WIDTH-1:0] ONE_NEG = 48'shFFFF_0000_0000;
    localparam logic signed [INTERNAL_WIDTH-1:0] TWO_POS = 48'sh0002_0000_0000;
    localparam logic signed [INTERNAL_WIDTH-1:0] TWO_NEG = 48'shFFFE_0000_0000;
    localparam logic signed [INTERNAL_WIDTH-1:0] Q_MAX   = 48'sh7FFF_FFFF_FFFF;
    localparam logic signed [INTERNAL_WIDTH-1:0] Q_MIN   = 48'sh8000_0000_0000;

    localparam logic MODE_SHIFT  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ITER   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

endpackage

// File: rtl/q16_32_sat_sq.sv
// Combinational Q16.32 square: full-precision signed product, truncated back to
// Q16.32 and clamped to Q_MAX when the integer part no longer fits.
module q16_32_sat_sq
    import corr_pkg::*;
(
    input  logic signed [INTERNAL_WIDTH-1:0] i_a,
    output logic signed [INTERNAL_WIDTH-1:0] o_y,
    output logic                             o_ovf
);

    logic signed [2*INTERNAL_WIDTH-1:0] w_prod;
    logic signed [INTERNAL_WIDTH-1:0]   w_trunc;

    assign w_prod  = i_a * i_a;
    // A square is never negative, so any set bit above bit 78 means the value exceeds Q_MAX.
    assign o_ovf   = |w_prod[2*INTERNAL_WIDTH-1:INTERNAL_WIDTH+FRACTIONAL_BITS-1];
    assign w_trunc = INTERNAL_WIDTH'(w_prod >>> FRACTIONAL_BITS);
    assign o_y     = o_ovf ? Q_MAX : w_trunc;

endmodule

// File: rtl/corr_z_restore_q16_32.sv
// Post-CORDIC range restore: undoes the z-normalizer by doubling (linear mode) or
// squaring (exp mode) the result count_div times, saturating, one step per clock.
module corr_z_restore_q16_32
    import corr_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             mode,
    input  logic signed [INTERNAL_WIDTH-1:0] x_in,
    input  logic        [COUNT_WIDTH-1:0]    count_div,
    output logic signed [INTERNAL_WIDTH-1:0] x_out,
    output logic                             busy,
    output logic                             overflow,
    output logic                             done
);

    logic [1:0]                       r_state;
    logic signed [INTERNAL_WIDTH-1:0] r_acc;
    logic [COUNT_WIDTH-1:0]           r_cnt;
    logic                             r_mode;
    logic                             r_busy;
    logic                             r_ovf;
    logic                             r_done;

    logic signed [INTERNAL_WIDTH-1:0] w_sq;
    logic                             w_sq_ovf;
    logic signed [INTERNAL_WIDTH-1:0] w_shift;
    logic                             w_shift_ovf;
    logic signed [INTERNAL_WIDTH-1:0] w_step;
    logic                             w_step_ovf;

    q16_32_sat_sq u_sat_sq (
        .i_a   (r_acc),
        .o_y   (w_sq),
        .o_ovf (w_sq_ovf)
    );

    // Doubling overflows exactly when the two top bits differ; saturated values re-saturate.
    assign w_shift_ovf = r_acc[INTERNAL_WIDTH-1] ^ r_acc[INTERNAL_WIDTH-2];
    assign w_shift     = w_shift_ovf ? (r_acc[INTERNAL_WIDTH-1] ? Q_MIN : Q_MAX)
                                     : {r_acc[INTERNAL_WIDTH-2:0], 1'b0};

    assign w_step     = (r_mode == MODE_SQUARE) ? w_sq     : w_shift;
    assign w_step_ovf = (r_mode == MODE_SQUARE) ? w_sq_ovf : w_shift_ovf;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_SHIFT;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (enable) begin
                        r_acc  <= x_in;
                        r_cnt  <= count_div;
                        r_mode <= mode;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (count_div != '0) begin
                            r_state <= ITER;
                        end else begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    r_acc <= w_step;
                    r_ovf <= r_ovf | w_step_ovf;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == COUNT_WIDTH'(1)) begin
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign x_out    = r_acc;
    assign busy     = r_busy;
    assign overflow = r_ovf;
    assign done     = r_done;

endmodule
